// File: rtl/uart_autobaud_ctrl.sv
// rtl/uart_autobaud_ctrl.sv - auto-baud controller: disables uart_rx, times a 0x55 sync char, reprograms it
module uart_autobaud_ctrl #(
    parameter int DEFAULT_DIV  = 12,
    parameter int MIN_DIV      = 4,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  cfg_parity,
    input  logic [3:0]  cfg_byte_size,
    input  logic        cfg_stop_bits,
    input  logic        rxd,
    output logic [26:0] m_axis_config_tdata,
    output logic        m_axis_config_tvalid,
    input  logic        m_axis_config_tready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] measured_div
);

    localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_OFF, S_WAIT_FALL, S_MEASURE, S_WAIT_STOP, S_CFG_ON
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_rxd_d;
    logic [2:0]  r_cfg_parity;
    logic [3:0]  r_cfg_byte_size;
    logic        r_cfg_stop_bits;
    logic [19:0] r_cnt;
    logic [2:0]  r_falls;
    logic [TW-1:0] r_wait_cnt;
    logic [15:0] r_div;
    logic [15:0] r_stop_cnt;
    logic [15:0] r_measured_div;
    logic        r_done;
    logic        r_error;
    logic [1:0]  r_err_code;

    logic        w_fall;
    logic        w_fall5;
    logic [17:0] w_div_full;
    logic        w_div_bad;
    logic        w_timeout;
    logic        w_ovf;
    logic        w_err_set;
    logic [1:0]  w_err_code;

    assign w_fall     = ~rxd & r_rxd_d;
    assign w_fall5    = (r_state == S_MEASURE) && w_fall && (r_falls == 3'd4);
    // Fall 1 to fall 5 spans eight bit times; +4 rounds to nearest before the divide.
    assign w_div_full = 18'((21'(r_cnt) + 21'd4) >> 3);
    assign w_div_bad  = (w_div_full < 18'(MIN_DIV)) || (w_div_full > 18'h0FFFF);
    assign w_timeout  = (WAIT_TIMEOUT != 0) && (r_wait_cnt == TW'(WAIT_TIMEOUT - 1));
    assign w_ovf      = (r_cnt == 20'hFFFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CFG_OFF;
            end
            S_CFG_OFF: begin
                if (m_axis_config_tready) w_next = S_WAIT_FALL;
            end
            S_WAIT_FALL: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_fall) begin
                    w_next = S_MEASURE;
                end else if (w_timeout) begin
                    w_next     = S_IDLE;
                    w_err_set  = 1'b1;
                    w_err_code = 2'd1;
                end
            end
            S_MEASURE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_fall5) begin
                    if (w_div_bad) begin
                        w_next     = S_IDLE;
                        w_err_set  = 1'b1;
                        w_err_code = 2'd2;
                    end else begin
                        w_next = S_WAIT_STOP;
                    end
                end else if (w_ovf) begin
                    w_next     = S_IDLE;
                    w_err_set  = 1'b1;
                    w_err_code = 2'd3;
                end
            end
            S_WAIT_STOP: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (rxd && (r_stop_cnt + 16'd1 == r_div)) begin
                    w_next = S_CFG_ON;
                end
            end
            S_CFG_ON: begin
                if (m_axis_config_tready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_d         <= 1'b1;
            r_cfg_parity    <= 3'd0;
            r_cfg_byte_size <= 4'd0;
            r_cfg_stop_bits <= 1'b0;
            r_cnt           <= 20'd0;
            r_falls         <= 3'd0;
            r_wait_cnt      <= '0;
            r_div           <= 16'd0;
            r_stop_cnt      <= 16'd0;
            r_measured_div  <= 16'(DEFAULT_DIV);
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_err_code      <= 2'd0;
        end else begin
            r_rxd_d    <= rxd;
            r_done     <= 1'b0;
            r_error    <= w_err_set;
            r_err_code <= w_err_code;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg_parity    <= cfg_parity;
                        r_cfg_byte_size <= cfg_byte_size;
                        r_cfg_stop_bits <= cfg_stop_bits;
                    end
                end
                S_CFG_OFF: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT_FALL: begin
                    if (w_fall) begin
                        r_cnt   <= 20'd1;
                        r_falls <= 3'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    r_stop_cnt <= 16'd0;
                    if (w_fall) r_falls <= r_falls + 3'd1;
                    if (w_fall5) begin
                        r_div <= w_div_full[15:0];
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                S_WAIT_STOP: begin
                    if (!rxd) begin
                        r_stop_cnt <= 16'd0;
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 16'd1;
                    end
                end
                S_CFG_ON: begin
                    if (m_axis_config_tready) begin
                        r_measured_div <= r_div;
                        r_done         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy                 = (r_state != S_IDLE);
        m_axis_config_tvalid = 1'b0;
        m_axis_config_tdata  = 27'd0;
        if (r_state == S_CFG_OFF) begin
            m_axis_config_tvalid = 1'b1;
            m_axis_config_tdata  = {2'b00, 1'b0, r_cfg_stop_bits, r_cfg_byte_size,
                                    r_cfg_parity, r_measured_div};
        end else if (r_state == S_CFG_ON) begin
            m_axis_config_tvalid = 1'b1;
            m_axis_config_tdata  = {2'b00, 1'b1, r_cfg_stop_bits, r_cfg_byte_size,
                                    r_cfg_parity, r_div};
        end
    end

    assign done         = r_done;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign measured_div = r_measured_div;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb/tb_uart_autobaud_ctrl.sv - directed self-checking bench for uart_autobaud_ctrl
module tb_uart_autobaud_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [2:0]  cfg_parity;
    logic [3:0]  cfg_byte_size;
    logic        cfg_stop_bits;
    logic        rxd;
    logic [26:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] measured_div;

    int          checks = 0;
    int          errors = 0;
    logic [26:0] words[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [1:0]  last_code = 2'd0;

    uart_autobaud_ctrl #(
        .DEFAULT_DIV (12),
        .MIN_DIV     (4),
        .WAIT_TIMEOUT(1000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .cfg_parity          (cfg_parity),
        .cfg_byte_size       (cfg_byte_size),
        .cfg_stop_bits       (cfg_stop_bits),
        .rxd                 (rxd),
        .m_axis_config_tdata (tdata),
        .m_axis_config_tvalid(tvalid),
        .m_axis_config_tready(tready),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .err_code            (err_code),
        .measured_div        (measured_div)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge sampling sees what the DUT acts on.
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid && tready) words.push_back(tdata);
            if (done) done_cnt++;
            if (error) begin
                err_cnt++;
                last_code = err_code;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] p, input logic [3:0] b, input logic s);
        cfg_parity    = p;
        cfg_byte_size = b;
        cfg_stop_bits = s;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic send_55(input int bit_clks, input int extra);
        logic [7:0] d;
        int         dur;
        d = 8'h55;
        for (int i = 0; i < 9; i++) begin
            rxd = (i == 0) ? 1'b0 : d[i-1];
            dur = bit_clks + ((i == 7) ? extra : 0);
            repeat (dur) tick();
        end
        rxd = 1'b1;
    endtask

    task automatic wait_event(input int d0, input int e0, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (done_cnt != d0 || err_cnt != e0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        checks++; if (tdata !== 27'd0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b error=%b expected 0/0", done, error); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        checks++; if (measured_div !== 16'd12) begin errors++; $display("FAIL reset_measured_div: got %0d expected 12", measured_div); end
    endtask

    task automatic test_nominal();
        int d0, e0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt;
        words.delete();
        pulse_start(3'd0, 4'd8, 1'b0);
        repeat (3) tick();
        checks++; if (words.size() != 1) begin errors++; $display("FAIL nominal_off_count: got %0d expected 1", words.size()); end
        else begin
            checks++; if (words[0] !== 27'h040000C) begin errors++; $display("FAIL nominal_off_word: got %h expected 040000c", words[0]); end
        end
        send_55(100, 0);
        wait_event(d0, e0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_wait: got no done expected done within bound"); end
        checks++; if (done_cnt != d0 + 1 || err_cnt != e0) begin errors++; $display("FAIL nominal_pulses: got done=%0d err=%0d expected %0d/%0d", done_cnt - d0, err_cnt - e0, 1, 0); end
        checks++; if (words.size() != 2) begin errors++; $display("FAIL nominal_on_count: got %0d expected 2", words.size()); end
        else begin
            checks++; if (words[1] !== 27'h1400064) begin errors++; $display("FAIL nominal_on_word: got %h expected 1400064", words[1]); end
        end
        checks++; if (measured_div !== 16'd100) begin errors++; $display("FAIL nominal_div: got %0d expected 100", measured_div); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int n, d0, e0;
        n = words.size(); d0 = done_cnt; e0 = err_cnt;
        tready = 1'b0;
        pulse_start(3'b101, 4'd7, 1'b1);
        cfg_parity = 3'd0; cfg_byte_size = 4'd0; cfg_stop_bits = 1'b0;
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== 27'h0BD0064 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got tvalid=%b tdata=%h busy=%b expected 1/0bd0064/1", i, tvalid, tdata, busy);
            end
            tick();
        end
        checks++; if (words.size() != n) begin errors++; $display("FAIL bp_no_handshake: got %0d words expected %0d", words.size() - n, 0); end
        tready = 1'b1;
        repeat (2) tick();
        checks++; if (words.size() != n + 1) begin errors++; $display("FAIL bp_one_word: got %0d words expected 1", words.size() - n); end
        else begin
            checks++; if (words[n] !== 27'h0BD0064) begin errors++; $display("FAIL bp_word: got %h expected 0bd0064", words[n]); end
        end
        checks++; if (tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_wait_fall: got tvalid=%b busy=%b expected 0/1", tvalid, busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_abort_busy: got %b expected 0", busy); end
        repeat (3) tick();
        checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL bp_abort_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_rounding();
        int d0, e0, n;
        bit ok;
        d0 = done_cnt; e0 = err_cnt;
        pulse_start(3'd0, 4'd8, 1'b0);
        repeat (3) tick();
        send_55(37, 0);
        wait_event(d0, e0, 500, ok);
        checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL round37_done: got %0d expected 1", done_cnt - d0); end
        checks++; if (measured_div !== 16'd37) begin errors++; $display("FAIL round37_div: got %0d expected 37", measured_div); end
        d0 = done_cnt; e0 = err_cnt; n = words.size();
        pulse_start(3'd0, 4'd8, 1'b0);
        repeat (3) tick();
        send_55(37, 3);
        wait_event(d0, e0, 500, ok);
        checks++; if (!ok || done_cnt != d0 + 1 || err_cnt != e0) begin errors++; $display("FAIL jitter_done: got done=%0d err=%0d expected 1/0", done_cnt - d0, err_cnt - e0); end
        checks++; if (words.size() != n + 2) begin errors++; $display("FAIL jitter_words: got %0d expected 2", words.size() - n); end
        else begin
            checks++; if (words[n] !== 27'h0400025) begin errors++; $display("FAIL jitter_off_word: got %h expected 0400025", words[n]); end
            checks++; if (words[n+1] !== 27'h1400025) begin errors++; $display("FAIL jitter_on_word: got %h expected 1400025", words[n+1]); end
        end
        checks++; if (measured_div !== 16'd37) begin errors++; $display("FAIL jitter_div: got %0d expected 37", measured_div); end
    endtask

    task automatic test_too_fast();
        int d0, e0, n;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; n = words.size();
        pulse_start(3'd0, 4'd8, 1'b0);
        repeat (3) tick();
        send_55(3, 0);
        wait_event(d0, e0, 100, ok);
        repeat (5) tick();
        checks++; if (!ok || err_cnt != e0 + 1 || done_cnt != d0) begin errors++; $display("FAIL fast_pulses: got err=%0d done=%0d expected 1/0", err_cnt - e0, done_cnt - d0); end
        checks++; if (last_code !== 2'd2) begin errors++; $display("FAIL fast_code: got %0d expected 2", last_code); end
        checks++; if (words.size() != n + 1) begin errors++; $display("FAIL fast_words: got %0d expected 1", words.size() - n); end
        checks++; if (measured_div !== 16'd37 || busy !== 1'b0) begin errors++; $display("FAIL fast_state: got div=%0d busy=%b expected 37/0", measured_div, busy); end
    endtask

    task automatic test_timeout();
        int n;
        rxd = 1'b1;
        n = 0;
        pulse_start(3'd0, 4'd8, 1'b0);
        for (int i = 0; i < 1100; i++) begin
            tick();
            n++;
            if (error === 1'b1) break;
        end
        checks++; if (n != 1001) begin errors++; $display("FAIL timeout_cycle: got %0d expected 1001", n); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL timeout_code: got %0d expected 1", err_code); end
        tick();
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL timeout_after: got busy=%b error=%b expected 0/0", busy, error); end
    endtask

    task automatic test_abort();
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt; n = words.size();
        pulse_start(3'd0, 4'd8, 1'b0);
        repeat (3) tick();
        rxd = 1'b0; repeat (37) tick();
        rxd = 1'b1; repeat (37) tick();
        rxd = 1'b0; repeat (10) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        rxd = 1'b1;
        repeat (20) tick();
        checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL abort_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); end
        checks++; if (measured_div !== 16'd37) begin errors++; $display("FAIL abort_div: got %0d expected 37", measured_div); end
        checks++; if (words.size() != n + 1) begin errors++; $display("FAIL abort_words: got %0d expected 1", words.size() - n); end
    endtask

    task automatic test_mid_reset();
        tready = 1'b0;
        pulse_start(3'd2, 4'd6, 1'b1);
        tick();
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL midrst_pre_tvalid: got %b expected 1", tvalid); end
        rst = 1'b1;
        tick();
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 27'd0) begin errors++; $display("FAIL midrst_clear: got tvalid=%b busy=%b tdata=%h expected 0/0/0", tvalid, busy, tdata); end
        checks++; if (measured_div !== 16'd12) begin errors++; $display("FAIL midrst_div: got %0d expected 12", measured_div); end
        rst = 1'b0;
        tready = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; rxd = 1'b1; tready = 1'b1;
        cfg_parity = 3'd0; cfg_byte_size = 4'd8; cfg_stop_bits = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_rounding();
        test_too_fast();
        test_timeout();
        test_abort();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
